// File: rtl/regfile_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_pkg
// Purpose  : Shared types and sizes for the register-file debug dumper.
// Contents : dump_state_t (IDLE, HALT, LOAD, SEND, FINISH), NUM_REGS,
//            REG_AW, XLEN, next_idx() helper (index advance mod 32).
// Revision : 1.0 - initial release
// ============================================================================
package regfile_dump_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int XLEN     = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALT   = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } dump_state_t;

  // Index advance; the natural 5-bit wrap gives the mod-32 behaviour.
  function automatic logic [REG_AW-1:0] next_idx(input logic [REG_AW-1:0] idx);
    return idx + {{(REG_AW-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Purpose  : Debug reader for the CPU register file. On start it requests a
//            pipeline halt, walks COUNT registers from START_IDX (mod 32)
//            through a dedicated read port and streams {index, value}
//            records over valid/ready, keeping a 32-bit additive checksum.
// Ports    : clk, rst (sync, active-high)
//            start                  - one-cycle dump request (IDLE only)
//            halt_req / halt_ack    - pipeline freeze handshake
//            rf_raddr / rf_rdata    - regfile read port (combinational data)
//            out_valid / out_ready  - record stream handshake
//            out_idx / out_data     - record contents
//            busy, done, checksum   - status
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int START_IDX = 0,
  parameter int COUNT     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_idx,
  output logic [XLEN-1:0]   out_data,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   checksum
);

  localparam logic [REG_AW-1:0] c_start_idx = REG_AW'(START_IDX);
  // Counter is one bit wider than the index so COUNT=32 is representable.
  localparam logic [REG_AW:0]   c_last_cnt  = (REG_AW+1)'(COUNT - 1);
  localparam logic [REG_AW:0]   c_cnt_one   = (REG_AW+1)'(1);

  dump_state_t       r_state;
  dump_state_t       w_next;
  logic [REG_AW-1:0] r_idx;
  logic [REG_AW:0]   r_cnt;
  logic              w_handshake;
  logic              w_last;

  assign w_handshake = (r_state == SEND) && out_ready;
  assign w_last      = (r_cnt == c_last_cnt);
  assign rf_raddr    = r_idx;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. halt_ack is only consulted in HALT: a drop later in
  // the dump is a protocol violation that the dump deliberately ignores.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)    w_next = HALT;
      HALT:    if (halt_ack) w_next = LOAD;
      LOAD:    w_next = SEND;
      SEND:    if (out_ready) w_next = w_last ? FINISH : LOAD;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Status outputs are flops loaded from the next state, so they change in
  // the same cycle as the state they describe.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_req  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      halt_req  <= (w_next != IDLE);
      out_valid <= (w_next == SEND);
      busy      <= (w_next != IDLE);
      done      <= (w_next == FINISH);
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: index walk, record capture, checksum.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= c_start_idx;
      r_cnt    <= '0;
      out_idx  <= '0;
      out_data <= '0;
      checksum <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_idx    <= c_start_idx;
        r_cnt    <= '0;
        checksum <= '0;
      end
      if (r_state == LOAD) begin
        out_idx  <= r_idx;
        out_data <= rf_rdata;
      end
      if (w_handshake) begin
        checksum <= checksum + out_data;
        r_idx    <= next_idx(r_idx);
        r_cnt    <= r_cnt + c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump
// Purpose  : Self-checking bench for regfile_dump. Instance a uses default
//            parameters; instance b uses START_IDX=30, COUNT=4 for wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a (defaults)
  logic        start_a, halt_req_a, halt_ack_a, out_valid_a, out_ready_a;
  logic        busy_a, done_a;
  logic [4:0]  rf_raddr_a, out_idx_a;
  logic [31:0] rf_rdata_a, out_data_a, checksum_a;
  logic [31:0] regs_a [32];
  assign rf_rdata_a = regs_a[rf_raddr_a];

  // instance b (wrap-around window)
  logic        start_b, halt_req_b, halt_ack_b, out_valid_b, out_ready_b;
  logic        busy_b, done_b;
  logic [4:0]  rf_raddr_b, out_idx_b;
  logic [31:0] rf_rdata_b, out_data_b, checksum_b;
  logic [31:0] regs_b [32];
  assign rf_rdata_b = regs_b[rf_raddr_b];

  regfile_dump dut_a (
    .clk(clk), .rst(rst), .start(start_a), .halt_req(halt_req_a),
    .halt_ack(halt_ack_a), .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_idx(out_idx_a),
    .out_data(out_data_a), .busy(busy_a), .done(done_a), .checksum(checksum_a)
  );

  regfile_dump #(.START_IDX(30), .COUNT(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .halt_req(halt_req_b),
    .halt_ack(halt_ack_b), .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_idx(out_idx_b),
    .out_data(out_data_b), .busy(busy_b), .done(done_b), .checksum(checksum_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full dump on instance a (START_IDX=0, COUNT=32). The expected record
  // stream is simply registers 0..31 in order; the sink is modelled here.
  //   ready_mode 0: always ready, 1: random, 2: stall 5 cycles on record 3
  //   poke: re-pulse start while busy (must be ignored)
  //   exp_cap: edge count (start-sampling edge = 1) at which a downstream
  //            flop captures done; 0 skips that check
  task automatic run_dump(input int ack_delay, input int ready_mode,
                          input bit poke, input int exp_cap);
    logic [4:0]  q_idx[$];
    logic [31:0] q_dat[$];
    logic [31:0] sum = 0;
    logic [4:0]  pidx = 0;
    logic [31:0] pdat = 0;
    logic        pv = 0, pr = 0;
    int e = 0, acc = 0, stall = 0, done_e = -1, first_v;
    for (int k = 0; k < 32; k++) begin
      q_idx.push_back(5'(k));
      q_dat.push_back(regs_a[k]);
    end
    first_v     = ((ack_delay < 1) ? 1 : ack_delay) + 2;
    halt_ack_a  = (ack_delay == 0);
    out_ready_a = 1'b0;
    start_a     = 1'b1;
    while (done_e < 0 && e < 400) begin
      tick();
      e++;
      start_a = 1'b0;
      if (e == 1) begin
        chk("halt_req latency", {31'd0, halt_req_a}, 32'd1);
        chk("busy on start", {31'd0, busy_a}, 32'd1);
      end
      if (ack_delay > 0 && e == ack_delay) halt_ack_a = 1'b1;
      if (e < first_v) begin
        chk("no valid before ack+2", {31'd0, out_valid_a}, 32'd0);
        chk("halt_req held", {31'd0, halt_req_a}, 32'd1);
      end
      if (e == first_v) chk("first valid at ack+2", {31'd0, out_valid_a}, 32'd1);
      chk("checksum running", checksum_a, sum);
      if (pv && !pr) begin
        chk("stall idx stable", {27'd0, out_idx_a}, {27'd0, pidx});
        chk("stall data stable", out_data_a, pdat);
      end
      if (done_a) begin
        done_e = e;
        chk("records accepted", 32'(acc), 32'd32);
        if (exp_cap > 0) chk("done capture edge", 32'(e + 1), 32'(exp_cap));
      end else begin
        case (ready_mode)
          0: out_ready_a = 1'b1;
          1: out_ready_a = 1'($urandom % 2);
          default: begin
            if (out_valid_a && acc == 3 && stall < 5) begin
              out_ready_a = 1'b0;
              stall++;
            end else begin
              out_ready_a = 1'b1;
            end
          end
        endcase
        if (out_valid_a && out_ready_a) begin
          if (q_idx.size() == 0) begin
            chk("extra record", 32'd1, 32'd0);
          end else begin
            chk("record idx", {27'd0, out_idx_a}, {27'd0, q_idx.pop_front()});
            chk("record data", out_data_a, q_dat.pop_front());
            sum = sum + out_data_a;
            acc++;
          end
        end
        pv = out_valid_a; pr = out_ready_a; pidx = out_idx_a; pdat = out_data_a;
        if (poke && acc == 5 && out_valid_a) start_a = 1'b1;
      end
    end
    if (done_e < 0) chk("done timeout", 32'd0, 32'd1);
    out_ready_a = 1'b0;
    start_a     = 1'b0;
    repeat (3) begin
      tick();
      chk("done single cycle", {31'd0, done_a}, 32'd0);
      chk("idle after dump", {31'd0, busy_a}, 32'd0);
      chk("halt_req dropped", {31'd0, halt_req_a}, 32'd0);
      chk("checksum held in idle", checksum_a, sum);
    end
  endtask

  initial begin
    logic [4:0]  b_idx[$];
    logic [31:0] b_dat[$];
    logic [31:0] b_sum;
    int          b_acc, b_done, npulse;

    rst = 1'b1;
    start_a = 0; halt_ack_a = 0; out_ready_a = 0;
    start_b = 0; halt_ack_b = 0; out_ready_b = 0;
    for (int k = 0; k < 32; k++) begin
      regs_a[k] = 32'(k) * 32'h11;
      regs_b[k] = $urandom;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst halt_req", {31'd0, halt_req_a}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst busy", {31'd0, busy_a}, 32'd0);
    chk("rst done", {31'd0, done_a}, 32'd0);
    chk("rst out_idx", {27'd0, out_idx_a}, 32'd0);
    chk("rst out_data", out_data_a, 32'd0);
    chk("rst checksum", checksum_a, 32'd0);
    chk("rst rf_raddr a", {27'd0, rf_raddr_a}, 32'd0);
    chk("rst rf_raddr b", {27'd0, rf_raddr_b}, 32'd30);

    // Full dump, x[i]=i*0x11, everything tied high
    run_dump(0, 0, 1'b0, 67);
    chk("full dump checksum", checksum_a, 32'h0000_20F0);

    // Random contents, halt_ack delayed 10 cycles, random ready, extra start
    for (int k = 1; k < 32; k++) regs_a[k] = $urandom;
    regs_a[0] = 32'd0;
    run_dump(10, 1, 1'b1, 0);

    // Five-cycle stall on record 3
    for (int k = 1; k < 32; k++) regs_a[k] = $urandom;
    run_dump(0, 2, 1'b0, 0);

    // Back-to-back dumps: checksum held, then restarts from zero
    for (int k = 1; k < 32; k++) regs_a[k] = $urandom;
    run_dump(0, 1, 1'b0, 0);
    for (int k = 1; k < 32; k++) regs_a[k] = $urandom;
    run_dump(0, 1, 1'b0, 0);

    // Extra start while busy, then rst in the middle of SEND
    halt_ack_a = 1'b1; out_ready_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (5) tick();
    out_ready_a = 1'b0;
    tick();
    chk("mid-dump in SEND", {31'd0, out_valid_a}, 32'd1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("start ignored while busy", {31'd0, out_valid_a}, 32'd1);
    chk("mid-dump idx", {27'd0, out_idx_a}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid halt_req", {31'd0, halt_req_a}, 32'd0);
    chk("rst mid busy", {31'd0, busy_a}, 32'd0);
    chk("rst mid out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst mid checksum", checksum_a, 32'd0);
    chk("rst mid out_data", out_data_a, 32'd0);
    chk("rst mid rf_raddr", {27'd0, rf_raddr_a}, 32'd0);
    npulse = 0;
    repeat (10) begin
      tick();
      if (done_a || busy_a) npulse++;
    end
    chk("no done/busy after rst", 32'(npulse), 32'd0);
    halt_ack_a = 1'b0;

    // Wrap-around on instance b: indices 30, 31, 0, 1
    regs_b[30] = 32'hFFFF_FFFF; regs_b[31] = 32'd2;
    regs_b[0]  = 32'd0;         regs_b[1]  = 32'd5;
    for (int k = 0; k < 4; k++) begin
      b_idx.push_back(5'((30 + k) % 32));
      b_dat.push_back(regs_b[(30 + k) % 32]);
    end
    b_sum = 0; b_acc = 0; b_done = 0;
    halt_ack_b = 1'b1; out_ready_b = 1'b1; start_b = 1'b1;
    for (int c = 0; c < 40 && b_done == 0; c++) begin
      tick();
      start_b = 1'b0;
      if (done_b) begin
        b_done = 1;
      end else if (out_valid_b && out_ready_b) begin
        if (b_idx.size() == 0) begin
          chk("wrap extra record", 32'd1, 32'd0);
        end else begin
          chk("wrap idx", {27'd0, out_idx_b}, {27'd0, b_idx.pop_front()});
          chk("wrap data", out_data_b, b_dat.pop_front());
          b_sum = b_sum + out_data_b;
          b_acc++;
        end
      end
    end
    chk("wrap done seen", 32'(b_done), 32'd1);
    chk("wrap records", 32'(b_acc), 32'd4);
    chk("wrap checksum model", checksum_b, b_sum);
    chk("wrap checksum value", checksum_b, 32'h0000_0006);
    out_ready_b = 1'b0;
    halt_ack_b  = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_dump.md
# regfile_dump

Debug reader for the CPU register file: on a start pulse it requests a pipeline halt, walks a contiguous range of architectural registers through a dedicated regfile read port, and streams each `{index, value}` record out over a valid/ready interface. It also produces a running 32-bit additive checksum of the values sent. It sits beside the `regfile`, driving a read-address port, and feeds a debug transport such as a UART TX or scan chain.

## Interface
- `START_IDX`, default 0: first register index dumped (0..31).
- `COUNT`, default 32: number of registers dumped (1..32). Indices advance mod 32.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: one-cycle request to begin a dump. Ignored unless the state is IDLE.
- `halt_req`, output, 1: asks the core to freeze writeback.
- `halt_ack`, input, 1: core confirms it is frozen. Must stay high until `halt_req` falls.
- `rf_raddr`, output, 5: read address to the regfile port.
- `rf_rdata`, input, 32: combinational read data for `rf_raddr`.
- `out_valid`, output, 1: a record is presented.
- `out_ready`, input, 1: the sink accepts the record.
- `out_idx`, output, 5: register index of the record.
- `out_data`, output, 32: register value of the record.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse after the last record is accepted.
- `checksum`, output, 32: sum mod 2^32 of all `out_data` accepted in the current dump.

## Operation
- States and transitions:
  - IDLE: on `start`, go to HALT.
  - HALT: hold `halt_req`; on `halt_ack`, go to LOAD.
  - LOAD: drive `rf_raddr`, capture the read data, go to SEND.
  - SEND: wait for `out_ready`.
    - On `out_ready`, if this was the last record, go to FINISH; otherwise go to LOAD.
  - FINISH: go to IDLE.
- HALT:
  - `halt_req` is 1.
  - `checksum` and the record counter are cleared on entry.
- LOAD:
  - `rf_raddr` = current index.
  - `rf_rdata` is registered into `out_data`, and the index into `out_idx`.
- SEND:
  - `out_valid` is 1.
  - `out_idx` and `out_data` are held stable until the handshake.
- Handshake (`out_valid && out_ready`):
  - `checksum += out_data`, wrapping mod 2^32.
  - Index = (index + 1) mod 32.
  - Counter is incremented.
- FINISH:
  - `done` is 1 for exactly one cycle.
  - `halt_req` drops at the end of this cycle.
- `checksum` holds its final value in IDLE until the next dump's HALT entry.
- `start` during `busy` has no effect. No queuing.
- `halt_ack` low while in LOAD or SEND is a protocol violation. Behaviour is unaffected: the dump continues.
- x0 is dumped like any other index. Its value comes from the regfile, expected 0.
- Wrap-around example: START_IDX=30, COUNT=4 dumps indices 30, 31, 0, 1.

## Timing
- Reset values: state IDLE; `halt_req`=0, `out_valid`=0, `busy`=0, `done`=0, `out_idx`=0, `out_data`=0, `checksum`=0, `rf_raddr`=START_IDX.
- All outputs are registered, except `rf_raddr`, which is a registered index.
- Latency:
  - `start` to `halt_req` high: 1 cycle.
  - `halt_ack` sampled high to first `out_valid`: 2 cycles (HALT→LOAD, LOAD→SEND).
  - Per-record throughput: 2 cycles minimum (LOAD + SEND with `out_ready` held high).
  - Full 32-register dump with `halt_ack` and `out_ready` always high: `start` at cycle 0, `done` at cycle 67.
- `rst` mid-dump: the next cycle is IDLE with all outputs at reset values. `halt_req` drops immediately and no `done` is produced.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- Shared package:
  - `dump_state_t` enum: IDLE, HALT, LOAD, SEND, FINISH.
  - `NUM_REGS`=32, `REG_AW`=5, `XLEN`=32.
- A single module, with no sub-module needed.
- The regfile needs a third combinational read port, or a mux onto `rs1` gated by `halt_req`. The integrating top owns that choice.

## Test plan
- Default params, regfile preloaded with x[i]=i*0x11, `halt_ack` and `out_ready` tied high → 32 records with idx 0..31 and data i*0x11; `done` at cycle 67; checksum 0x20F0.
- `halt_ack` delayed 10 cycles → `halt_req` is held and no `out_valid` appears until 2 cycles after `halt_ack` rises.
- `out_ready` low for 5 cycles on record 3 → `out_idx` and `out_data` stay stable throughout; no duplicate or skipped record; checksum unchanged until acceptance.
- START_IDX=30, COUNT=4, x30=0xFFFFFFFF, x31=2, x0=0, x1=5 → indices 30, 31, 0, 1 in order; checksum 0x00000006 (wrapped).
- `start` pulsed while busy, then `rst` asserted mid-SEND → the extra `start` is ignored; after `rst`, state is IDLE, `halt_req`=0, `checksum`=0, and no `done` pulse.
- Two back-to-back dumps → the second checksum restarts from 0 and the first dump's value is held in IDLE in between.
